piso_serializer: RTL and testbench
==================================

PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter N, default 8: word width in bits; legal N >= 2.
REQ-002 Parameter INIT, default {N{1'b0}}: shift-register content after reset.
REQ-003 CLK  input  1  clock; all state changes on rising edge.
REQ-004 RSTN  input  1  reset, asynchronous, active-low.
REQ-005 CE  input  1  clock enable, active-high; CE=0 freezes all state.
REQ-006 DIN  input  N  parallel word to serialize.
REQ-007 LOAD  input  1  word-valid request, active-high.
REQ-008 READY  output  1  word can be accepted this cycle (combinational from state).
REQ-009 Q  output  1  serial data out, MSB first.
REQ-010 QV  output  1  high while Q carries a valid bit.
REQ-011 LAST  output  1  high while Q carries the final bit of a frame.

Function
REQ-012 Two states: IDLE and SHIFT; bit counter CNT, width ceil(log2(F)), where F is frame length (N, or N+1 with parity).
REQ-013 READY = 1 in IDLE, or in SHIFT with CNT = F-1; 0 otherwise.
REQ-014 Accept = LOAD & READY & CE at a rising edge; LOAD without accept is ignored and not queued.
REQ-015 On accept: shift register <= DIN, CNT <= 0, state <= SHIFT; Q = DIN[N-1] in the following cycle (1-cycle latency).
REQ-016 In SHIFT, Q = shift register MSB, QV = 1; each CE edge with CNT < F-1 shifts left by one (LSB filled with 0) and increments CNT.
REQ-017 LAST = 1 in SHIFT when CNT = F-1.
REQ-018 CE edge at CNT = F-1 with no accept: state <= IDLE; with accept: new frame starts per REQ-015, no idle gap (back-to-back).
REQ-019 In IDLE: Q = 0, QV = 0, LAST = 0.
REQ-020 CE = 0: state, CNT, shift register and outputs hold; no accept occurs.
REQ-021 Bit order matches the team's serial-in shift register: N bits sent MSB first reassemble to DIN at the receiver after N CE edges.

Reset
REQ-022 RSTN = 0 immediately (asynchronously) forces state IDLE, CNT = 0, shift register = INIT, Q = 0, QV = 0, LAST = 0, READY = 1.
REQ-023 Reset mid-frame aborts the frame; remaining bits are discarded; first edge after RSTN release with accept starts a fresh frame.
REQ-024 RSTN release is synchronous-safe: no state change on the release edge unless an accept condition is met at that edge.

Configuration
REQ-025 Macro PISO_SERIALIZER_PARITY_EN: when defined, F = N+1 and an even-parity bit (XOR of the accepted DIN) is sent after DIN[0], with LAST on the parity bit.
REQ-026 Without PISO_SERIALIZER_PARITY_EN: F = N, no parity logic present, LAST on DIN[0].

Verification
REQ-027 N=8, CE=1, one accept of DIN=8'hA5 -> Q = 1,0,1,0,0,1,0,1 over next 8 cycles, QV high 8 cycles, LAST only on 8th, then IDLE with Q=0, QV=0.
REQ-028 Back-to-back: 8'hA5 accepted, LOAD held with DIN=8'h3C at LAST cycle -> 16 continuous QV cycles, Q = A5 bits then 0,0,1,1,1,1,0,0.
REQ-029 CE toggling 1,0,1,0... during 8'hA5 -> each bit held 2 cycles, total 16 QV cycles, sequence unchanged; LOAD during CE=0 not accepted.
REQ-030 LOAD=1 with DIN=8'hFF during CNT=3 of 8'hA5 -> ignored, READY=0, A5 sequence completes unaltered.
REQ-031 RSTN pulsed low at CNT=4 of 8'hA5 -> Q=0, QV=0, READY=1 without clock edge; next accept of 8'h81 serializes 1,0,0,0,0,0,0,1.
REQ-032 PISO_SERIALIZER_PARITY_EN defined: 8'hA5 -> 9 bits ending 0, LAST on 9th; 8'h07 -> 9th bit 1.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter, MSB first, with back-to-back frame support.
// Optional even-parity trailer bit when PISO_SERIALIZER_PARITY_EN is defined.
module piso_serializer #(
  parameter int          N    = 8,
  parameter logic [N-1:0] INIT = '0
) (
  input  logic         CLK,
  input  logic         RSTN,
  input  logic         CE,
  input  logic [N-1:0] DIN,
  input  logic         LOAD,
  output logic         READY,
  output logic         Q,
  output logic         QV,
  output logic         LAST,
  output logic         dbg_state
);

`ifdef PISO_SERIALIZER_PARITY_EN
  localparam int F = N + 1;
`else
  localparam int F = N;
`endif
  localparam int             CW       = $clog2(F);
  localparam logic [CW-1:0]  CNT_LAST = CW'(F - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [N-1:0]  sreg, sreg_n;
  logic          at_last;
  logic          accept;

`ifdef PISO_SERIALIZER_PARITY_EN
  logic par, par_n;
`endif

  assign at_last   = (state == SHIFT) && (cnt == CNT_LAST);
  assign READY     = (state == IDLE) || at_last;
  assign accept    = LOAD && READY && CE;
  assign dbg_state = state;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state <= IDLE;
      cnt   <= '0;
      sreg  <= INIT;
`ifdef PISO_SERIALIZER_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      sreg  <= sreg_n;
`ifdef PISO_SERIALIZER_PARITY_EN
      par   <= par_n;
`endif
    end
  end

  // A new word may replace the final bit of the current frame in the same edge.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sreg_n  = sreg;
`ifdef PISO_SERIALIZER_PARITY_EN
    par_n   = par;
`endif
    if (CE) begin
      if (accept) begin
        state_n = SHIFT;
        cnt_n   = '0;
        sreg_n  = DIN;
`ifdef PISO_SERIALIZER_PARITY_EN
        par_n   = ^DIN;
`endif
      end else if (state == SHIFT) begin
        if (cnt == CNT_LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          sreg_n = {sreg[N-2:0], 1'b0};
          cnt_n  = cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    Q    = 1'b0;
    QV   = 1'b0;
    LAST = 1'b0;
    if (state == SHIFT) begin
      QV   = 1'b1;
      LAST = at_last;
`ifdef PISO_SERIALIZER_PARITY_EN
      Q    = at_last ? par : sreg[N-1];
`else
      Q    = sreg[N-1];
`endif
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer; frames are predicted into exp_q as {last, bit}.
// Build with PISO_SERIALIZER_PARITY_EN defined to exercise the parity trailer.
module tb_piso_serializer;
  localparam int N = 8;

  logic         CLK;
  logic         RSTN;
  logic         CE;
  logic [N-1:0] DIN;
  logic         LOAD;
  logic         READY;
  logic         Q;
  logic         QV;
  logic         LAST;
  logic         dbg_state;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];

  piso_serializer #(.N(N)) dut (
    .CLK(CLK), .RSTN(RSTN), .CE(CE), .DIN(DIN), .LOAD(LOAD),
    .READY(READY), .Q(Q), .QV(QV), .LAST(LAST), .dbg_state(dbg_state)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // expected serial frame for one accepted word
  task automatic push_frame(input logic [N-1:0] w);
    for (int i = N - 1; i >= 0; i--) begin
`ifdef PISO_SERIALIZER_PARITY_EN
      exp_q.push_back({1'b0, w[i]});
`else
      exp_q.push_back({(i == 0), w[i]});
`endif
    end
`ifdef PISO_SERIALIZER_PARITY_EN
    exp_q.push_back({1'b1, ^w});
`endif
  endtask

  function automatic logic model_ready();
    return (exp_q.size() == 0) || exp_q[0][1];
  endfunction

  task automatic check_out(input string tag);
    if (exp_q.size() > 0) begin
      check({tag, ".q"},     Q,     exp_q[0][0]);
      check({tag, ".qv"},    QV,    1'b1);
      check({tag, ".last"},  LAST,  exp_q[0][1]);
      check({tag, ".ready"}, READY, exp_q[0][1]);
      check({tag, ".state"}, dbg_state, 1'b1);
    end else begin
      check({tag, ".q"},     Q,     1'b0);
      check({tag, ".qv"},    QV,    1'b0);
      check({tag, ".last"},  LAST,  1'b0);
      check({tag, ".ready"}, READY, 1'b1);
      check({tag, ".state"}, dbg_state, 1'b0);
    end
  endtask

  // driver: called at a falling edge with inputs already set for the next rising edge
  task automatic cycle(input string tag);
    logic acc;
    check_out(tag);
    acc = LOAD && CE && model_ready();
    @(posedge CLK);
    if (CE) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (acc) push_frame(DIN);
    end
    @(negedge CLK);
  endtask

  task automatic send(input string tag, input logic [N-1:0] w);
    LOAD = 1'b1;
    DIN  = w;
    cycle(tag);
    LOAD = 1'b0;
  endtask

  task automatic run_to_last(input string tag);
    int guard = 0;
    while (!(exp_q.size() > 0 && exp_q[0][1]) && guard < 40) begin
      cycle(tag);
      guard++;
    end
    check({tag, ".reached_last"}, (exp_q.size() > 0), 1'b1);
  endtask

  initial begin
    RSTN = 1'b0;
    CE   = 1'b1;
    LOAD = 1'b0;
    DIN  = '0;
    #2;
    check_out("reset_async");
    repeat (2) @(negedge CLK);
    check_out("reset_held");
    RSTN = 1'b1;
    repeat (2) cycle("reset_release");

    // single frame
    send("a5", 8'hA5);
    repeat (11) cycle("a5");

    // back-to-back frames, second word presented on the final bit
    send("b2b", 8'hA5);
    run_to_last("b2b");
    LOAD = 1'b1;
    DIN  = 8'h3C;
    cycle("b2b_join");
    LOAD = 1'b0;
    repeat (11) cycle("b2b");

    // CE toggling; LOAD only asserted while CE is low
    send("ce", 8'hA5);
    for (int i = 0; i < 22; i++) begin
      CE   = (i % 2 == 1);
      LOAD = !CE;
      DIN  = 8'hFF;
      cycle("ce");
    end
    CE   = 1'b1;
    LOAD = 1'b0;
    repeat (3) cycle("ce_tail");

    // LOAD while busy is dropped
    send("busy", 8'hA5);
    repeat (3) cycle("busy");
    LOAD = 1'b1;
    DIN  = 8'hFF;
    cycle("busy_load");
    LOAD = 1'b0;
    repeat (8) cycle("busy");

    // asynchronous reset mid-frame
    send("rst", 8'hA5);
    repeat (4) cycle("rst");
    RSTN = 1'b0;
    exp_q.delete();
    #1;
    check_out("rst_async");
    #2;
    RSTN = 1'b1;
    send("r81", 8'h81);
    repeat (10) cycle("r81");

    // parity sensitivity and another back-to-back pair
    send("w07", 8'h07);
    run_to_last("w07");
    LOAD = 1'b1;
    DIN  = 8'h5E;
    cycle("w5e_join");
    LOAD = 1'b0;
    repeat (11) cycle("w5e");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=0 expected=1");
    $fatal(1, "timeout");
  end
endmodule
